// File: rtl/contador_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
// Legality check and terminal-value helper used at elaboration and in logic.
package contador_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic bit params_ok(
    input int w,
    input int m,
    input int rv
  );
    return (w >= 1) && (w <= 16) &&
           (m >= 2) && (m <= (1 << w)) &&
           (rv >= 0) && (rv < m);
  endfunction

  function automatic int unsigned terminal_val(
    input logic        up_down,
    input int unsigned modulus
  );
    return (up_down == DIR_UP) ? modulus - 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/contador_next_calc.sv
// Combinational next-state for the modulo counter.
// Priority: load > en > hold; compares are done one bit wider than count.
module contador_next_calc
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_evt,
  output logic             tc_evt,
  output logic             range_err
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [WIDTH:0] MOD_X = W1'(MODULUS);
  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   ld_x;
  logic [WIDTH:0]   term_x;
  logic [WIDTH-1:0] step;
  logic             at_term;

  always_comb begin
    cnt_x      = {1'b0, count};
    ld_x       = {1'b0, load_value};
    term_x     = W1'(terminal_val(up_down, MODULUS));
    // Going up, anything at or past the top is treated as terminal
    at_term    = (up_down == DIR_UP) ? (cnt_x >= term_x)
                                     : (cnt_x == term_x);
    step       = (up_down == DIR_UP) ? count + ONE : count - ONE;
    next_count = count;
    wrap_evt   = 1'b0;
    tc_evt     = 1'b0;
    range_err  = 1'b0;
    if (load) begin
      range_err  = (ld_x >= MOD_X);
      next_count = range_err ? MOD_M1 : load_value;
    end else if (en) begin
      if (!at_term) begin
        next_count = step;
      end else begin
        tc_evt = 1'b1;
        if (!sat) begin
          wrap_evt   = 1'b1;
          next_count = (up_down == DIR_UP) ? '0 : MOD_M1;
        end
      end
    end
  end

endmodule

// File: rtl/contador_mod_updown.sv
// Parametrised modulo up/down counter with load, saturate and flags.
// carry_out is the zero-latency enable for a cascaded next stage.
module contador_mod_updown
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULUS     = 10,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             tc_pulse,
  output logic             wrap_flag,
  output logic             load_err
);

  localparam int unsigned W1 = WIDTH + 1;
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);

  if (!params_ok(int'(WIDTH), int'(MODULUS), int'(RESET_VALUE)))
  begin : g_bad_params
    $error("contador_mod_updown: illegal WIDTH/MODULUS/RESET_VALUE");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic [WIDTH-1:0] nxt;
  logic             wrap_evt, tc_evt, range_err;
  logic [WIDTH:0]   term_x;

  contador_next_calc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count_q),
    .en         (en),
    .up_down    (up_down),
    .sat        (sat),
    .load       (load),
    .load_value (load_value),
    .next_count (nxt),
    .wrap_evt   (wrap_evt),
    .tc_evt     (tc_evt),
    .range_err  (range_err)
  );

  always_comb begin
    count_d = nxt;
    tc_d    = tc_evt;
    lerr_d  = range_err;
    // A wrap in the same cycle as clr_flag keeps the flag set
    wrap_d  = wrap_evt ? 1'b1 : (clr_flag ? 1'b0 : wrap_q);
    term_x  = W1'(terminal_val(up_down, MODULUS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_V;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign carry_out = en & ~load & ~reset &
                     ({1'b0, count_q} == term_x);
  assign count     = count_q;
  assign tc_pulse  = tc_q;
  assign wrap_flag = wrap_q;
  assign load_err  = lerr_q;

endmodule

// File: tb/tb_contador_mod_updown.sv
// Directed bench for the modulo up/down counter (mod-10 and legacy mod-4).
module tb_contador_mod_updown;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_down = 1'b1;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic       clr_flag = 1'b0;
  logic [3:0] count;
  logic       carry_out, tc_pulse, wrap_flag, load_err;

  logic       l_reset = 1'b1;
  logic       l_en = 1'b0;
  logic [1:0] l_count;
  logic       l_carry, l_tc, l_wrap, l_lerr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  contador_mod_updown #(
    .WIDTH(4), .MODULUS(10), .RESET_VALUE(0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .up_down    (up_down),
    .sat        (sat),
    .load       (load),
    .load_value (load_value),
    .clr_flag   (clr_flag),
    .count      (count),
    .carry_out  (carry_out),
    .tc_pulse   (tc_pulse),
    .wrap_flag  (wrap_flag),
    .load_err   (load_err)
  );

  contador_mod_updown #(
    .WIDTH(2), .MODULUS(4), .RESET_VALUE(0)
  ) legacy (
    .clk        (clk),
    .reset      (l_reset),
    .en         (l_en),
    .up_down    (1'b1),
    .sat        (1'b0),
    .load       (1'b0),
    .load_value (2'b00),
    .clr_flag   (1'b0),
    .count      (l_count),
    .carry_out  (l_carry),
    .tc_pulse   (l_tc),
    .wrap_flag  (l_wrap),
    .load_err   (l_lerr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b1; load_value = 4'd3; en = 1'b1;
    tick();
    checks += 4;
    if (count !== 4'd0) begin errors++;
      $display("FAIL reset_count got=%0d exp=0", count); end
    if (tc_pulse !== 1'b0) begin errors++;
      $display("FAIL reset_tc got=%b exp=0", tc_pulse); end
    if (wrap_flag !== 1'b0) begin errors++;
      $display("FAIL reset_wrap got=%b exp=0", wrap_flag); end
    if (load_err !== 1'b0) begin errors++;
      $display("FAIL reset_lerr got=%b exp=0", load_err); end
    reset = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_up_wrap;
    up_down = 1'b1; sat = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks += 4;
      if (count !== 4'(i % 10)) begin errors++;
        $display("FAIL up_count[%0d] got=%0d exp=%0d", i, count, i % 10); end
      if (tc_pulse !== (i == 10)) begin errors++;
        $display("FAIL up_tc[%0d] got=%b exp=%b", i, tc_pulse, i == 10); end
      if (wrap_flag !== (i >= 10)) begin errors++;
        $display("FAIL up_wrap[%0d] got=%b exp=%b", i, wrap_flag, i >= 10); end
      if (carry_out !== (i % 10 == 9)) begin errors++;
        $display("FAIL up_carry[%0d] got=%b exp=%b", i, carry_out, i % 10 == 9); end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_down;
    logic [3:0] exp_c [4] = '{4'd0, 4'd9, 4'd8, 4'd7};
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    checks++;
    if (wrap_flag !== 1'b0) begin errors++;
      $display("FAIL down_clr got=%b exp=0", wrap_flag); end
    do_load(4'd0);
    up_down = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks += 4;
      if (count !== exp_c[i]) begin errors++;
        $display("FAIL down_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]); end
      if (carry_out !== (i == 0)) begin errors++;
        $display("FAIL down_carry[%0d] got=%b exp=%b", i, carry_out, i == 0); end
      if (tc_pulse !== (i == 1)) begin errors++;
        $display("FAIL down_tc[%0d] got=%b exp=%b", i, tc_pulse, i == 1); end
      if (wrap_flag !== (i >= 1)) begin errors++;
        $display("FAIL down_wrap[%0d] got=%b exp=%b", i, wrap_flag, i >= 1); end
      if (i < 3) tick();
    end
    en = 1'b0; up_down = 1'b1;
  endtask

  task automatic test_sat;
    logic exp_tc [3] = '{1'b0, 1'b1, 1'b1};
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    up_down = 1'b1; sat = 1'b1;
    do_load(4'd8);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 3;
      if (count !== 4'd9) begin errors++;
        $display("FAIL sat_count[%0d] got=%0d exp=9", i, count); end
      if (tc_pulse !== exp_tc[i]) begin errors++;
        $display("FAIL sat_tc[%0d] got=%b exp=%b", i, tc_pulse, exp_tc[i]); end
      if (wrap_flag !== 1'b0) begin errors++;
        $display("FAIL sat_wrap[%0d] got=%b exp=0", i, wrap_flag); end
    end
    en = 1'b0;
    tick();
    checks += 2;
    if (count !== 4'd9) begin errors++;
      $display("FAIL sat_hold_count got=%0d exp=9", count); end
    if (tc_pulse !== 1'b0) begin errors++;
      $display("FAIL sat_hold_tc got=%b exp=0", tc_pulse); end
    up_down = 1'b0;
    do_load(4'd0);
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 2;
      if (count !== 4'd0) begin errors++;
        $display("FAIL sat_dn_count[%0d] got=%0d exp=0", i, count); end
      if (tc_pulse !== 1'b1) begin errors++;
        $display("FAIL sat_dn_tc[%0d] got=%b exp=1", i, tc_pulse); end
    end
    en = 1'b0; sat = 1'b0; up_down = 1'b1;
  endtask

  task automatic test_load_err;
    logic [3:0] lv [4]    = '{4'd13, 4'd5, 4'd10, 4'd9};
    logic [3:0] exp_c [4] = '{4'd9, 4'd5, 4'd9, 4'd9};
    logic       exp_e [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    en = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load = 1'b1;
      load_value = lv[i];
      tick();
      checks += 3;
      if (count !== exp_c[i]) begin errors++;
        $display("FAIL load_count[%0d] got=%0d exp=%0d", i, count, exp_c[i]); end
      if (load_err !== exp_e[i]) begin errors++;
        $display("FAIL load_err[%0d] got=%b exp=%b", i, load_err, exp_e[i]); end
      if (tc_pulse !== 1'b0) begin errors++;
        $display("FAIL load_tc[%0d] got=%b exp=0", i, tc_pulse); end
    end
    load = 1'b1; load_value = 4'd15;
    tick();
    load = 1'b0; en = 1'b0;
    tick();
    checks += 2;
    if (load_err !== 1'b0) begin errors++;
      $display("FAIL load_err_drop got=%b exp=0", load_err); end
    if (count !== 4'd9) begin errors++;
      $display("FAIL load_hold got=%0d exp=9", count); end
  endtask

  task automatic test_wrap_clr;
    clr_flag = 1'b1;
    tick();
    clr_flag = 1'b0;
    do_load(4'd9);
    up_down = 1'b1; sat = 1'b0; en = 1'b1; clr_flag = 1'b1;
    #1;
    checks++;
    if (carry_out !== 1'b1) begin errors++;
      $display("FAIL wc_carry got=%b exp=1", carry_out); end
    tick();
    checks += 3;
    if (count !== 4'd0) begin errors++;
      $display("FAIL wc_count got=%0d exp=0", count); end
    if (wrap_flag !== 1'b1) begin errors++;
      $display("FAIL wc_set_wins got=%b exp=1", wrap_flag); end
    if (tc_pulse !== 1'b1) begin errors++;
      $display("FAIL wc_tc got=%b exp=1", tc_pulse); end
    en = 1'b0;
    tick();
    clr_flag = 1'b0;
    checks += 2;
    if (wrap_flag !== 1'b0) begin errors++;
      $display("FAIL wc_clear got=%b exp=0", wrap_flag); end
    if (tc_pulse !== 1'b0) begin errors++;
      $display("FAIL wc_tc_drop got=%b exp=0", tc_pulse); end
  endtask

  task automatic test_reset_mid;
    do_load(4'd9);
    up_down = 1'b1; en = 1'b1; reset = 1'b1;
    #1;
    checks++;
    if (carry_out !== 1'b0) begin errors++;
      $display("FAIL rm_carry_rst got=%b exp=0", carry_out); end
    reset = 1'b0; load = 1'b1;
    #1;
    checks++;
    if (carry_out !== 1'b0) begin errors++;
      $display("FAIL rm_carry_load got=%b exp=0", carry_out); end
    load = 1'b0;
    tick();
    en = 1'b0;
    do_load(4'd7);
    checks += 2;
    if (count !== 4'd7 || wrap_flag !== 1'b1) begin errors++;
      $display("FAIL rm_setup got=%0d/%b exp=7/1", count, wrap_flag); end
    if (tc_pulse !== 1'b0) begin errors++;
      $display("FAIL rm_load_tc got=%b exp=0", tc_pulse); end
    reset = 1'b1; load = 1'b1; load_value = 4'd3; en = 1'b1;
    tick();
    reset = 1'b0; load = 1'b0; en = 1'b0;
    checks += 3;
    if (count !== 4'd0) begin errors++;
      $display("FAIL rm_count got=%0d exp=0", count); end
    if (tc_pulse !== 1'b0) begin errors++;
      $display("FAIL rm_tc got=%b exp=0", tc_pulse); end
    if (wrap_flag !== 1'b0) begin errors++;
      $display("FAIL rm_wrap got=%b exp=0", wrap_flag); end
  endtask

  task automatic test_legacy;
    logic [1:0] ref2;
    logic [1:0] prev;
    l_reset = 1'b1;
    tick();
    l_reset = 1'b0; l_en = 1'b1;
    ref2 = 2'd0;
    prev = 2'd0;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks += 3;
      if (l_count !== ref2) begin errors++;
        $display("FAIL leg_count[%0d] got=%0d exp=%0d", i, l_count, ref2); end
      if (l_carry !== (ref2 == 2'd3)) begin errors++;
        $display("FAIL leg_carry[%0d] got=%b exp=%b", i, l_carry, ref2 == 2'd3); end
      if (l_tc !== (i > 0 && prev == 2'd3)) begin errors++;
        $display("FAIL leg_tc[%0d] got=%b exp=%b", i, l_tc, i > 0 && prev == 2'd3); end
      prev = ref2;
      ref2 = ref2 + 2'd1;
      tick();
    end
    l_en = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_up_wrap();
    test_down();
    test_sat();
    test_load_err();
    test_wrap_clr();
    test_reset_mid();
    test_legacy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
